// File: rtl/ro_race_pkg.sv
// Shared definitions for the ring-oscillator race counter.
// Holds the race FSM state type and the default parameter values
// used by ro_race_counter and ro_chan_counter.
package ro_race_pkg;

  localparam int unsigned DEF_NUM_CH = 4;
  localparam int unsigned DEF_CNT_W  = 8;
  localparam int unsigned DEF_TO_W   = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ro_chan_counter.sv
// One race channel: event qualifier, event counter and reach flag.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   clear     - zero the counter (accepted start)
//   run       - race is in progress; events are counted only then
//   sig       - ring-oscillator output for this channel (clk-synchronous)
//   goal      - latched event goal (never 0 while run is high)
//   reach     - this channel's qualifying event completes the goal this cycle
module ro_chan_counter
  import ro_race_pkg::*;
#(
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned EDGE_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             run,
  input  logic             sig,
  input  logic [CNT_W-1:0] goal,
  output logic             reach
);

  logic             sig_prev;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] goal_m1;
  logic             evt;

  always_comb begin
    evt     = (EDGE_MODE != 0) ? (sig & ~sig_prev) : sig;
    goal_m1 = goal - CNT_W'(1);
    reach   = run & evt & (count == goal_m1);
  end

  // sig_prev tracks the input every cycle, so a level already high
  // when the race starts does not register as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_prev <= 1'b0;
      count    <= '0;
    end else begin
      sig_prev <= sig;
      if (clear) begin
        count <= '0;
      end else if (run && evt) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ro_race_counter.sv
// Ring-oscillator race: NUM_CH channels count events until one reaches
// the latched goal, or a RUN-cycle timer expires.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   start     - begin a race (accepted only in IDLE with goal != 0)
//   goal      - event count to finish, latched on accepted start
//   signal    - per-channel oscillator outputs, synchronous to clk
//   busy      - high in RUN and DONE
//   done      - one-cycle result pulse
//   winner    - lowest index among channels finishing in the deciding cycle
//   tie       - more than one channel finished in the deciding cycle
//   timeout   - race ended with no channel finishing
module ro_race_counter
  import ro_race_pkg::*;
#(
  parameter int unsigned NUM_CH    = DEF_NUM_CH,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned TO_W      = DEF_TO_W,
  parameter int unsigned EDGE_MODE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CNT_W-1:0]          goal,
  input  logic [NUM_CH-1:0]         signal,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(NUM_CH)-1:0] winner,
  output logic                      tie,
  output logic                      timeout
);

  localparam int unsigned WIN_W = $clog2(NUM_CH);
  localparam int unsigned PC_W  = $clog2(NUM_CH + 1);

  state_t            state;
  logic [CNT_W-1:0]  goal_q;
  logic [TO_W-1:0]   timer;
  logic [NUM_CH-1:0] reach;
  logic              accept;
  logic              run;
  logic [WIN_W-1:0]  first;
  logic [PC_W-1:0]   hits;

  always_comb begin
    accept = (state == IDLE) && start && (goal != '0);
    run    = (state == RUN);
  end

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_chan
    ro_chan_counter #(
      .CNT_W     (CNT_W),
      .EDGE_MODE (EDGE_MODE)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .clear (accept),
      .run   (run),
      .sig   (signal[g]),
      .goal  (goal_q),
      .reach (reach[g])
    );
  end

  // Lowest-index priority encoder and reach popcount in one pass.
  always_comb begin
    first = '0;
    hits  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (reach[i]) begin
        if (hits == '0) first = WIN_W'(i);
        hits = hits + PC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      goal_q  <= '0;
      timer   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      winner  <= '0;
      tie     <= 1'b0;
      timeout <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            goal_q  <= goal;
            timer   <= '0;
            winner  <= '0;
            tie     <= 1'b0;
            timeout <= 1'b0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          timer <= timer + TO_W'(1);
          // A reach wins over a timer expiry in the same cycle.
          if (|reach) begin
            winner  <= first;
            tie     <= (hits > PC_W'(1));
            timeout <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else if (&timer) begin
            winner  <= '0;
            tie     <= 1'b0;
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_race_counter.sv
// Bench for ro_race_counter: a level-mode and an edge-mode instance share
// stimulus; expected results come from a race model that finds, per channel,
// the RUN cycle at which its cumulative event count meets the goal.
module tb_ro_race_counter;

  localparam int NCH  = 4;
  localparam int CW   = 8;
  localparam int TW   = 6;
  localparam int TMAX = 64;   // 2**TW RUN cycles before timeout
  localparam int WIN  = 70;   // observation window per race, in cycles

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [CW-1:0]  goal = '0;
  logic [NCH-1:0] signal = '0;

  logic [1:0]      busy_o, done_o, tie_o, to_o;
  logic [1:0][1:0] win_o;

  ro_race_counter #(.NUM_CH(NCH), .CNT_W(CW), .TO_W(TW), .EDGE_MODE(0)) dut_lvl (
    .clk(clk), .rst(rst), .start(start), .goal(goal), .signal(signal),
    .busy(busy_o[0]), .done(done_o[0]), .winner(win_o[0]), .tie(tie_o[0]),
    .timeout(to_o[0]));

  ro_race_counter #(.NUM_CH(NCH), .CNT_W(CW), .TO_W(TW), .EDGE_MODE(1)) dut_edge (
    .clk(clk), .rst(rst), .start(start), .goal(goal), .signal(signal),
    .busy(busy_o[1]), .done(done_o[1]), .winner(win_o[1]), .tie(tie_o[1]),
    .timeout(to_o[1]));

  int errors = 0;
  int checks = 0;

  logic [NCH-1:0] pat [0:WIN+1];
  logic [NCH-1:0] sig_pre;

  int   exp_k [2];
  int   exp_w [2];
  bit   exp_t [2];
  bit   exp_to[2];

  int         obs_k  [2];
  logic [1:0] obs_win[2];
  logic       obs_tie[2];
  logic       obs_to [2];
  bit         busy_bad[2], extra_done[2], clr_bad[2], held_bad[2];

  // Race model: events per RUN cycle k (1-based) come from pat[k];
  // edge mode needs the previous cycle's value (sig_pre before k=1).
  function automatic void model(input int mode, input int g, output int d,
                                output int w, output bit t, output bit to);
    int cnt[NCH];
    int at[NCH];
    logic [NCH-1:0] prev;
    int best, n;
    bit ev;
    for (int i = 0; i < NCH; i++) begin cnt[i] = 0; at[i] = 0; end
    prev = sig_pre;
    for (int k = 1; k <= TMAX; k++) begin
      for (int i = 0; i < NCH; i++) begin
        ev = (mode == 1) ? (pat[k][i] && !prev[i]) : pat[k][i];
        if (ev && at[i] == 0) begin
          cnt[i]++;
          if (cnt[i] == g) at[i] = k;
        end
      end
      prev = pat[k];
    end
    best = 0;
    for (int i = 0; i < NCH; i++)
      if (at[i] != 0 && (best == 0 || at[i] < best)) best = at[i];
    if (best == 0) begin
      d = TMAX; w = 0; t = 1'b0; to = 1'b1;
    end else begin
      d = best; w = -1; n = 0;
      for (int i = 0; i < NCH; i++)
        if (at[i] == best) begin
          if (w < 0) w = i;
          n++;
        end
      t = (n > 1); to = 1'b0;
    end
  endfunction

  task automatic predict(input int g);
    int d;
    for (int m = 0; m < 2; m++) begin
      model(m, g, d, exp_w[m], exp_t[m], exp_to[m]);
      exp_k[m] = d + 1;  // done appears one cycle after the deciding cycle
    end
  endtask

  // Drives one race: idle cycle, start cycle t, then WIN cycles; records
  // what each DUT showed, with k counting cycles after t.
  task automatic run_race(input int g, input bit poke);
    for (int m = 0; m < 2; m++) begin
      obs_k[m] = -1; obs_win[m] = '0; obs_tie[m] = 1'b0; obs_to[m] = 1'b0;
      busy_bad[m] = 1'b0; extra_done[m] = 1'b0; clr_bad[m] = 1'b0; held_bad[m] = 1'b0;
    end
    @(negedge clk); start = 1'b0; signal = sig_pre;
    @(negedge clk); start = 1'b1; goal = CW'(g); signal = sig_pre;
    for (int k = 1; k <= WIN; k++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (k == 1 && (win_o[m] !== 2'd0 || tie_o[m] !== 1'b0 || to_o[m] !== 1'b0))
          clr_bad[m] = 1'b1;
        if (done_o[m] === 1'b1) begin
          if (obs_k[m] < 0) begin
            obs_k[m] = k; obs_win[m] = win_o[m]; obs_tie[m] = tie_o[m]; obs_to[m] = to_o[m];
          end else extra_done[m] = 1'b1;
        end else if (obs_k[m] >= 0 && (win_o[m] !== obs_win[m] ||
                     tie_o[m] !== obs_tie[m] || to_o[m] !== obs_to[m])) begin
          held_bad[m] = 1'b1;
        end
        if (busy_o[m] !== ((obs_k[m] < 0) || (k == obs_k[m]))) busy_bad[m] = 1'b1;
      end
      start  = poke && (k == 3);
      goal   = (poke && k == 3) ? CW'(1) : CW'($urandom);
      signal = pat[k];
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; goal = 8'd3; signal = '1;
    repeat (2) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if ({busy_o[m], done_o[m], win_o[m], tie_o[m], to_o[m]} !== 6'b0) begin
        errors++;
        $display("FAIL reset m=%0d: busy=%b done=%b winner=%0d tie=%b timeout=%b, all must be 0",
                 m, busy_o[m], done_o[m], win_o[m], tie_o[m], to_o[m]);
      end
    end
    rst = 1'b0; start = 1'b0; signal = '0;
  endtask

  task automatic test_level_single();
    sig_pre = 4'b0100;
    for (int k = 0; k <= WIN + 1; k++) pat[k] = 4'b0100;
    predict(37);
    run_race(37, 1'b1);
    checks++;
    if (obs_k[0] !== 38) begin
      errors++; $display("FAIL single_done_cycle: got t+%0d, want t+38", obs_k[0]);
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs_k[m] !== exp_k[m] || obs_win[m] !== 2'(exp_w[m]) ||
          obs_tie[m] !== exp_t[m] || obs_to[m] !== exp_to[m]) begin
        errors++;
        $display("FAIL single m=%0d: k=%0d w=%0d tie=%b to=%b, want k=%0d w=%0d tie=%b to=%b",
                 m, obs_k[m], obs_win[m], obs_tie[m], obs_to[m], exp_k[m], exp_w[m], exp_t[m], exp_to[m]);
      end
    end
  endtask

  task automatic test_tie();
    sig_pre = 4'b0000;
    for (int k = 0; k <= WIN + 1; k++) pat[k] = 4'b1010;
    predict(5);
    run_race(5, 1'b0);
    checks++;
    if (obs_k[0] !== 6 || obs_win[0] !== 2'd1 || obs_tie[0] !== 1'b1) begin
      errors++;
      $display("FAIL tie_level: k=%0d w=%0d tie=%b, want k=6 w=1 tie=1", obs_k[0], obs_win[0], obs_tie[0]);
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs_k[m] !== exp_k[m] || obs_win[m] !== 2'(exp_w[m]) ||
          obs_tie[m] !== exp_t[m] || obs_to[m] !== exp_to[m]) begin
        errors++;
        $display("FAIL tie m=%0d: k=%0d w=%0d tie=%b to=%b, want k=%0d w=%0d tie=%b to=%b",
                 m, obs_k[m], obs_win[m], obs_tie[m], obs_to[m], exp_k[m], exp_w[m], exp_t[m], exp_to[m]);
      end
    end
  endtask

  task automatic test_timeout();
    sig_pre = 4'b0000;
    for (int k = 0; k <= WIN + 1; k++) pat[k] = 4'b0000;
    run_race(10, 1'b0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs_k[m] !== 65 || obs_to[m] !== 1'b1 || obs_win[m] !== 2'd0 || obs_tie[m] !== 1'b0) begin
        errors++;
        $display("FAIL timeout m=%0d: k=%0d to=%b w=%0d tie=%b, want k=65 to=1 w=0 tie=0",
                 m, obs_k[m], obs_to[m], obs_win[m], obs_tie[m]);
      end
    end
    // Channel 1 completes in the very cycle the timer expires.
    for (int k = 0; k <= WIN + 1; k++) pat[k] = 4'b0010;
    predict(64);
    run_race(64, 1'b0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs_k[m] !== exp_k[m] || obs_win[m] !== 2'(exp_w[m]) || obs_to[m] !== exp_to[m]) begin
        errors++;
        $display("FAIL reach_vs_timeout m=%0d: k=%0d w=%0d to=%b, want k=%0d w=%0d to=%b",
                 m, obs_k[m], obs_win[m], obs_to[m], exp_k[m], exp_w[m], exp_to[m]);
      end
    end
  endtask

  task automatic test_edge();
    sig_pre = 4'b1000;
    for (int k = 0; k <= WIN + 1; k++) pat[k] = {1'b1, 2'b00, 1'(k % 2)};
    predict(4);
    run_race(4, 1'b1);
    checks++;
    if (obs_k[1] !== 8 || obs_win[1] !== 2'd0 || obs_to[1] !== 1'b0) begin
      errors++;
      $display("FAIL edge_toggle: k=%0d w=%0d to=%b, want k=8 w=0 to=0", obs_k[1], obs_win[1], obs_to[1]);
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs_k[m] !== exp_k[m] || obs_win[m] !== 2'(exp_w[m]) ||
          obs_tie[m] !== exp_t[m] || obs_to[m] !== exp_to[m]) begin
        errors++;
        $display("FAIL edge m=%0d: k=%0d w=%0d tie=%b to=%b, want k=%0d w=%0d tie=%b to=%b",
                 m, obs_k[m], obs_win[m], obs_tie[m], obs_to[m], exp_k[m], exp_w[m], exp_t[m], exp_to[m]);
      end
    end
  endtask

  // goal==0 start must be ignored and previous results stay held.
  task automatic test_ignored_start();
    bit bad[2];
    bad[0] = 1'b0; bad[1] = 1'b0;
    @(negedge clk); start = 1'b1; goal = '0; signal = '1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); start = 1'b0;
      for (int m = 0; m < 2; m++)
        if (busy_o[m] !== 1'b0 || done_o[m] !== 1'b0 || win_o[m] !== 2'(exp_w[m]) ||
            to_o[m] !== exp_to[m]) bad[m] = 1'b1;
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (bad[m]) begin
        errors++;
        $display("FAIL goal0_start m=%0d: busy=%b done=%b w=%0d, want busy=0 done=0 w=%0d held",
                 m, busy_o[m], done_o[m], win_o[m], exp_w[m]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit bad[2];
    @(negedge clk); signal = 4'b0001;
    @(negedge clk); start = 1'b1; goal = 8'd20;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1; start = 1'b1; goal = 8'd2;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if ({busy_o[m], done_o[m], win_o[m], tie_o[m], to_o[m]} !== 6'b0) begin
        errors++;
        $display("FAIL mid_run_reset m=%0d: busy=%b done=%b w=%0d tie=%b to=%b, all must be 0",
                 m, busy_o[m], done_o[m], win_o[m], tie_o[m], to_o[m]);
      end
    end
    rst = 1'b0; start = 1'b0;
    bad[0] = 1'b0; bad[1] = 1'b0;
    repeat (40) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) if (done_o[m] !== 1'b0 || busy_o[m] !== 1'b0) bad[m] = 1'b1;
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (bad[m]) begin
        errors++; $display("FAIL post_reset_quiet m=%0d: saw done/busy=1, want both 0", m);
      end
    end
  endtask

  task automatic test_random();
    int g, thr[NCH];
    bit poke;
    for (int r = 0; r < 24; r++) begin
      g = ($urandom_range(0, 9) < 7) ? int'($urandom_range(1, 20)) : int'($urandom_range(30, 80));
      sig_pre = NCH'($urandom);
      for (int i = 0; i < NCH; i++) thr[i] = $urandom_range(0, 100);
      for (int k = 0; k <= WIN + 1; k++)
        for (int i = 0; i < NCH; i++) pat[k][i] = ($urandom_range(0, 99) < thr[i]);
      poke = (g >= 3) && ($urandom_range(0, 1) == 1);
      predict(g);
      run_race(g, poke);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs_k[m] !== exp_k[m] || obs_win[m] !== 2'(exp_w[m]) ||
            obs_tie[m] !== exp_t[m] || obs_to[m] !== exp_to[m]) begin
          errors++;
          $display("FAIL rand%0d m=%0d g=%0d: k=%0d w=%0d tie=%b to=%b, want k=%0d w=%0d tie=%b to=%b",
                   r, m, g, obs_k[m], obs_win[m], obs_tie[m], obs_to[m],
                   exp_k[m], exp_w[m], exp_t[m], exp_to[m]);
        end
        checks++;
        if (busy_bad[m] || extra_done[m] || clr_bad[m] || held_bad[m]) begin
          errors++;
          $display("FAIL rand%0d_ctrl m=%0d: busy_bad=%b extra_done=%b clr_bad=%b held_bad=%b, want all 0",
                   r, m, busy_bad[m], extra_done[m], clr_bad[m], held_bad[m]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_level_single();
    test_tie();
    test_timeout();
    test_edge();
    test_ignored_start();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
